// File: rtl/padovan_system_if.sv
// Host-side bundle for the Padovan engine: start/index request, status, result and debug read.
// The host drives the master modport and the engine implements the slave modport.
interface padovan_system_if #(
  parameter int unsigned DATAWIDTH  = 8,
  parameter int unsigned INDEXWIDTH = 8
);
  logic                  iStart;
  logic [INDEXWIDTH-1:0] iIndex;
  logic                  oBusy;
  logic                  oDone;
  logic [DATAWIDTH-1:0]  oResult;
  logic                  oOverflow;
  logic [2:0]            iDbgSel;
  logic [DATAWIDTH-1:0]  oDbgData;

  modport master (
    output iStart, iIndex, iDbgSel,
    input  oBusy, oDone, oResult, oOverflow, oDbgData
  );

  modport slave (
    input  iStart, iIndex, iDbgSel,
    output oBusy, oDone, oResult, oOverflow, oDbgData
  );
endinterface

// File: rtl/padovan_system.sv
// Padovan-series engine: 8-entry register file, two operand buses, adder and sequencer FSM.
// Define PADOVAN_SAT_EN to make the adder saturate (sticky for the run) instead of wrapping.
module padovan_system #(
  parameter int unsigned DATAWIDTH  = 8,
  parameter int unsigned INDEXWIDTH = 8
) (
  input logic              Clk_System,
  input logic              Rst_System,
  padovan_system_if.slave  bus
);

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StAdd,
    StMov0,
    StMov1,
    StMov2,
    StDone
  } stateT;

  stateT stateQ, stateD;

  // R0..R3 live in regQ; R4 (k) and R5 (n) are index-wide; R6/R7 are constants.
  logic [DATAWIDTH-1:0]  regQ [4];
  logic [DATAWIDTH-1:0]  regD [4];
  logic [INDEXWIDTH-1:0] idxQ, idxD;
  logic [INDEXWIDTH-1:0] nQ, nD;
  logic [INDEXWIDTH-1:0] idxInc;
  logic                  flagQ, flagD;

  logic                  busyQ, doneQ, ovfQ;
  logic [DATAWIDTH-1:0]  resultQ;

  // Control word decoded from the current state
  logic [2:0]            aSel;
  logic [2:0]            bSel;
  logic [1:0]            cDest;
  logic                  cWe;
  logic                  aluAdd;
  logic                  ldInit;
  logic                  ldIndex;
  logic                  incIdx;

  logic [DATAWIDTH-1:0]  rfView [8];
  logic [DATAWIDTH-1:0]  busA;
  logic [DATAWIDTH-1:0]  busB;
  logic [DATAWIDTH:0]    sum;
  logic                  carry;
  logic [DATAWIDTH-1:0]  busC;

  assign idxInc = idxQ + INDEXWIDTH'(1);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk_System) begin
    if (Rst_System) begin
      stateQ <= StIdle;
    end else begin
      stateQ <= stateD;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StIdle: if (bus.iStart) stateD = StInit;
      StInit: stateD = (nQ <= INDEXWIDTH'(2)) ? StDone : StAdd;
      StAdd:  stateD = StMov0;
      StMov0: stateD = StMov1;
      StMov1: stateD = StMov2;
      StMov2: stateD = (idxInc == nQ) ? StDone : StAdd;
      StDone: stateD = StIdle;
      default: stateD = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: control outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    aSel    = 3'd0;
    bSel    = 3'd1;
    cDest   = 2'd0;
    cWe     = 1'b0;
    aluAdd  = 1'b0;
    ldInit  = 1'b0;
    ldIndex = 1'b0;
    incIdx  = 1'b0;
    unique case (stateQ)
      StIdle: ldIndex = bus.iStart;
      StInit: ldInit  = 1'b1;
      StAdd: begin
        aSel   = 3'd0;
        bSel   = 3'd1;
        aluAdd = 1'b1;
        cDest  = 2'd3;
        cWe    = 1'b1;
      end
      StMov0: begin
        aSel  = 3'd1;
        cDest = 2'd0;
        cWe   = 1'b1;
      end
      StMov1: begin
        aSel  = 3'd2;
        cDest = 2'd1;
        cWe   = 1'b1;
      end
      StMov2: begin
        aSel   = 3'd3;
        cDest  = 2'd2;
        cWe    = 1'b1;
        incIdx = 1'b1;
      end
      StDone: ;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: register-file read view, operand buses, adder, bus C
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rfView[i] = regQ[i];
    end
    rfView[4] = DATAWIDTH'(idxQ);
    rfView[5] = DATAWIDTH'(nQ);
    rfView[6] = DATAWIDTH'(1);
    rfView[7] = DATAWIDTH'(37);
  end

  assign busA  = rfView[aSel];
  assign busB  = rfView[bSel];
  assign sum   = {1'b0, busA} + {1'b0, busB};
  assign carry = sum[DATAWIDTH];

  always_comb begin
    busC = busA;
    if (aluAdd) begin
`ifdef PADOVAN_SAT_EN
      // Once saturated, stay saturated so later wrapped sums cannot look valid.
      busC = (carry || flagQ) ? {DATAWIDTH{1'b1}} : sum[DATAWIDTH-1:0];
`else
      busC = sum[DATAWIDTH-1:0];
`endif
    end
  end

  always_comb begin
    regD = regQ;
    idxD = idxQ;
    nD   = nQ;
    flagD = flagQ;
    if (ldIndex) begin
      nD = bus.iIndex;
    end
    if (ldInit) begin
      regD[0] = DATAWIDTH'(1);
      regD[1] = DATAWIDTH'(1);
      regD[2] = DATAWIDTH'(1);
      idxD    = INDEXWIDTH'(2);
      flagD   = 1'b0;
    end
    if (cWe) begin
      regD[cDest] = busC;
    end
    if (aluAdd && carry) begin
      flagD = 1'b1;
    end
    if (incIdx) begin
      idxD = idxInc;
    end
  end

  // Outputs are loaded from next-state values so they are valid in the DONE cycle itself.
  always_ff @(posedge Clk_System) begin
    if (Rst_System) begin
      for (int i = 0; i < 4; i++) begin
        regQ[i] <= '0;
      end
      idxQ    <= '0;
      nQ      <= '0;
      flagQ   <= 1'b0;
      busyQ   <= 1'b0;
      doneQ   <= 1'b0;
      resultQ <= '0;
      ovfQ    <= 1'b0;
    end else begin
      regQ  <= regD;
      idxQ  <= idxD;
      nQ    <= nD;
      flagQ <= flagD;
      busyQ <= (stateD != StIdle);
      doneQ <= (stateD == StDone);
      if (stateD == StDone) begin
        resultQ <= regD[2];
        ovfQ    <= flagD;
      end
    end
  end

  assign bus.oBusy     = busyQ;
  assign bus.oDone     = doneQ;
  assign bus.oResult   = resultQ;
  assign bus.oOverflow = ovfQ;
  assign bus.oDbgData  = rfView[bus.iDbgSel];

endmodule

// File: tb/tb_padovan_system.sv
// Self-checking bench for padovan_system: directed scenarios plus random runs
// compared against a series-level reference model.
module tb_padovan_system;
  localparam int unsigned DW = 8;
  localparam int unsigned IW = 8;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  padovan_system_if #(.DATAWIDTH(DW), .INDEXWIDTH(IW)) bus ();

  padovan_system #(.DATAWIDTH(DW), .INDEXWIDTH(IW)) dut (
    .Clk_System (clk),
    .Rst_System (rst),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // Reference: P(n) from the recurrence, with wrap or sticky saturation.
  function automatic void model(input int n, output int unsigned val, output bit ovf);
    int unsigned p[$];
    int unsigned maxv;
    int unsigned s;
    maxv = (1 << DW) - 1;
    p = {1, 1, 1};
    ovf = 1'b0;
    for (int k = 3; k <= n; k++) begin
      s = p[k-2] + p[k-3];
`ifdef PADOVAN_SAT_EN
      if (s > maxv || ovf) begin
        ovf = 1'b1;
        s = maxv;
      end
`else
      if (s > maxv) begin
        ovf = 1'b1;
        s = s - (maxv + 1);
      end
`endif
      p.push_back(s);
    end
    val = p[n];
  endfunction

  function automatic int latency(input int n);
    return (n <= 2) ? 2 : 2 + 4 * (n - 2);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a run at the next edge; optionally pulse iStart (index 3) at cycle pulseAt.
  task automatic do_run(input int n, input int pulseAt, output int lat,
                        output logic [DW-1:0] res, output logic ovf, output int dones);
    bus.iIndex = IW'(n);
    bus.iStart = 1'b1;
    tick();
    bus.iStart = 1'b0;
    lat = 1;
    dones = 0;
    while (!bus.oDone && lat < 2000) begin
      if (lat == pulseAt) begin
        bus.iStart = 1'b1;
        bus.iIndex = IW'(3);
      end else begin
        bus.iStart = 1'b0;
      end
      tick();
      lat++;
    end
    bus.iStart = 1'b0;
    res = bus.oResult;
    ovf = bus.oOverflow;
    if (bus.oDone) dones = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.oDone) dones++;
    end
    checks++;
    if (bus.oResult !== res) begin
      errors++;
      $display("FAIL result_hold n=%0d: got %0d required %0d", n, bus.oResult, res);
    end
  endtask

  task automatic check_run(input string name, input int n, input int pulseAt);
    int unsigned expVal;
    bit          expOvf;
    int          lat;
    logic [DW-1:0] res;
    logic        ovf;
    int          dones;
    model(n, expVal, expOvf);
    do_run(n, pulseAt, lat, res, ovf, dones);
    checks++;
    if (res !== DW'(expVal)) begin
      errors++;
      $display("FAIL %s_result n=%0d: got %0d required %0d", name, n, res, expVal);
    end
    checks++;
    if (ovf !== expOvf) begin
      errors++;
      $display("FAIL %s_overflow n=%0d: got %0b required %0b", name, n, ovf, expOvf);
    end
    checks++;
    if (lat != latency(n)) begin
      errors++;
      $display("FAIL %s_latency n=%0d: got %0d required %0d", name, n, lat, latency(n));
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL %s_done_count n=%0d: got %0d required 1", name, n, dones);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.iStart = 1'b0;
    bus.iIndex = '0;
    bus.iDbgSel = 3'd0;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({bus.oBusy, bus.oDone, bus.oOverflow} !== 3'b000 || bus.oResult !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%0b done=%0b ovf=%0b res=%0d required all 0",
               bus.oBusy, bus.oDone, bus.oOverflow, bus.oResult);
    end
    for (int s = 0; s < 6; s++) begin
      bus.iDbgSel = 3'(s);
      #1;
      checks++;
      if (bus.oDbgData !== '0) begin
        errors++;
        $display("FAIL reset_reg R%0d: got %0d required 0", s, bus.oDbgData);
      end
    end
    bus.iDbgSel = 3'd0;
  endtask

  task automatic test_small_index();
    for (int n = 0; n <= 2; n++) check_run("small", n, -1);
  endtask

  task automatic test_index_trace();
    int q[$];
    int exp[$];
    int lat;
    exp = {2, 3, 4, 5};
    bus.iDbgSel = 3'd4;
    bus.iIndex = IW'(5);
    bus.iStart = 1'b1;
    tick();
    bus.iStart = 1'b0;
    lat = 1;
    while (!bus.oDone && lat < 200) begin
      tick();
      lat++;
      if (q.size() == 0 || q[q.size()-1] != int'(bus.oDbgData)) q.push_back(int'(bus.oDbgData));
    end
    checks++;
    if (lat != 14) begin
      errors++;
      $display("FAIL trace_latency: got %0d required 14", lat);
    end
    checks++;
    if (bus.oResult !== DW'(3)) begin
      errors++;
      $display("FAIL trace_result: got %0d required 3", bus.oResult);
    end
    checks++;
    if (q != exp) begin
      errors++;
      $display("FAIL trace_R4: got %p required %p", q, exp);
    end
    bus.iDbgSel = 3'd0;
    tick();
  endtask

  task automatic test_overflow();
    check_run("ovf", 20, -1);
    check_run("ovf", 21, -1);
  endtask

  task automatic test_ignore_start();
    check_run("ignore", 10, 5);
    check_run("ignore", 7, 12);
  endtask

  task automatic test_mid_reset();
    int dones;
    bus.iIndex = IW'(15);
    bus.iStart = 1'b1;
    tick();
    bus.iStart = 1'b0;
    for (int c = 1; c < 20; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus.oBusy !== 1'b0 || bus.oResult !== '0 || bus.oDone !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs: got busy=%0b res=%0d done=%0b required 0/0/0",
               bus.oBusy, bus.oResult, bus.oDone);
    end
    dones = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (bus.oDone || bus.oBusy) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL midreset_activity: got %0d active cycles required 0", dones);
    end
    check_run("after_reset", 4, -1);
  endtask

  task automatic test_debug_consts();
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) begin
        bus.iIndex = IW'(9);
        bus.iStart = 1'b1;
        tick();
        bus.iStart = 1'b0;
        tick();
        tick();
      end
      bus.iDbgSel = 3'd6;
      #1;
      checks++;
      if (bus.oDbgData !== DW'(1)) begin
        errors++;
        $display("FAIL dbg_R6 pass=%0d: got %0d required 1", pass, bus.oDbgData);
      end
      bus.iDbgSel = 3'd7;
      #1;
      checks++;
      if (bus.oDbgData !== DW'(37)) begin
        errors++;
        $display("FAIL dbg_R7 pass=%0d: got %0d required 37", pass, bus.oDbgData);
      end
    end
    bus.iDbgSel = 3'd0;
    for (int c = 0; c < 200 && bus.oBusy; c++) tick();
    tick();
  endtask

  task automatic test_back_to_back();
    int doneAt[$];
    logic [DW-1:0] res[$];
    int c;
    bus.iIndex = IW'(3);
    bus.iStart = 1'b1;
    c = 0;
    while (doneAt.size() < 3 && c < 200) begin
      tick();
      c++;
      if (bus.oDone) begin
        doneAt.push_back(c);
        res.push_back(bus.oResult);
      end
    end
    bus.iStart = 1'b0;
    checks++;
    if (doneAt.size() != 3) begin
      errors++;
      $display("FAIL b2b_done_count: got %0d required 3", doneAt.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (res[i] !== DW'(2)) begin
          errors++;
          $display("FAIL b2b_result run=%0d: got %0d required 2", i, res[i]);
        end
      end
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (doneAt[i] - doneAt[i-1] != latency(3) + 1) begin
          errors++;
          $display("FAIL b2b_gap run=%0d: got %0d required %0d", i,
                   doneAt[i] - doneAt[i-1], latency(3) + 1);
        end
      end
    end
    for (int k = 0; k < 200 && bus.oBusy; k++) tick();
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++) begin
      check_run("random", int'($urandom_range(0, 40)), -1);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.iStart = 1'b0;
    bus.iIndex = '0;
    bus.iDbgSel = 3'd0;
    test_reset();
    test_small_index();
    test_index_trace();
    test_overflow();
    test_ignore_start();
    test_mid_reset();
    test_debug_consts();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
